// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_t;

    localparam logic [3:0] MIN_DATA_BITS = 4'd5;

    // Clamp a requested data length into MIN_DATA_BITS..max_bits.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                   input logic [3:0] max_bits);
        if (req < MIN_DATA_BITS) begin
            return MIN_DATA_BITS;
        end else if (req > max_bits) begin
            return max_bits;
        end
        return req;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side handshake, frame configuration and line signals of the UART TX.
interface uart_tx_cfg_if #(
    parameter int UART_DATA_WIDTH   = 8,
    parameter int CONFIG_DATA_WIDTH = 32
);
    logic [CONFIG_DATA_WIDTH-1:0] uart_config_data;
    logic [3:0]                   i_Num_Bits;
    logic [1:0]                   i_Parity;
    logic                         i_Stop_Bits;
    logic                         i_Tx_DV;
    logic [UART_DATA_WIDTH-1:0]   i_Tx_Byte;
    logic                         o_Tx_Ready;
    logic                         o_Tx_Active;
    logic                         o_Tx_Serial;
    logic                         o_Tx_Done;

    modport master (
        output uart_config_data, i_Num_Bits, i_Parity, i_Stop_Bits, i_Tx_DV, i_Tx_Byte,
        input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );

    modport slave (
        input  uart_config_data, i_Num_Bits, i_Parity, i_Stop_Bits, i_Tx_DV, i_Tx_Byte,
        output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: bit_end marks the last cycle of each (divisor+1)-cycle bit.
module uart_bit_timer #(
    parameter int CONFIG_DATA_WIDTH = 32
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic                         load,
    input  logic [CONFIG_DATA_WIDTH-1:0] divisor,
    output logic                         bit_end
);
    localparam logic [CONFIG_DATA_WIDTH-1:0] ONE = {{(CONFIG_DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [CONFIG_DATA_WIDTH-1:0] clk_count_reg;

    // Equality match means an all-ones divisor never needs the counter to wrap.
    assign bit_end = (clk_count_reg == divisor);

    // Count within a bit; restart on load or at the end of every bit period.
    always_ff @(posedge i_Clock) begin
        if (i_Reset || load || bit_end) begin
            clk_count_reg <= '0;
        end else begin
            clk_count_reg <= clk_count_reg + ONE;
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5..UART_DATA_WIDTH data bits,
// none/even/odd parity, 1 or 2 stop bits). Format and divisor latch per frame.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int UART_DATA_WIDTH   = 8,
    parameter int CONFIG_DATA_WIDTH = 32
) (
    input  logic         i_Clock,
    input  logic         i_Reset,
    uart_tx_cfg_if.slave tx_if
);
    localparam logic [3:0] MAX_BITS = 4'(UART_DATA_WIDTH);

    tx_state_t                    state_reg, state_next;
    logic [UART_DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic [3:0]                   bit_cnt_reg, bit_cnt_next;
    logic                         stop_cnt_reg, stop_cnt_next;
    logic                         serial_reg, serial_next;
    logic                         done_reg, done_next;

    logic [CONFIG_DATA_WIDTH-1:0] div_reg;
    logic [3:0]                   nbits_reg;
    parity_t                      parity_reg;
    logic                         stop2_reg;
    logic                         par_bit_reg;

    logic                         accept;
    logic                         bit_end;
    logic [3:0]                   nbits_clamped;
    logic [UART_DATA_WIDTH-1:0]   data_mask;
    parity_t                      parity_in;
    logic                         par_bit_in;

    assign accept        = (state_reg == IDLE) && tx_if.i_Tx_DV;
    assign nbits_clamped = clamp_data_bits(tx_if.i_Num_Bits, MAX_BITS);

    // Only bits below the clamped length take part in parity.
    generate
        for (genvar gi = 0; gi < UART_DATA_WIDTH; gi++) begin : g_mask
            assign data_mask[gi] = (4'(gi) < nbits_clamped);
        end
    endgenerate

    // Code 11 behaves as "no parity".
    assign parity_in  = (tx_if.i_Parity == 2'b01) ? PAR_EVEN :
                        (tx_if.i_Parity == 2'b10) ? PAR_ODD  : PAR_NONE;
    assign par_bit_in = (^(tx_if.i_Tx_Byte & data_mask)) ^ (parity_in == PAR_ODD);

    // Frame format and divisor are captured only at accept, so mid-frame changes wait.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            div_reg     <= '0;
            nbits_reg   <= '0;
            parity_reg  <= PAR_NONE;
            stop2_reg   <= 1'b0;
            par_bit_reg <= 1'b0;
        end else if (accept) begin
            div_reg     <= tx_if.uart_config_data;
            nbits_reg   <= nbits_clamped;
            parity_reg  <= parity_in;
            stop2_reg   <= tx_if.i_Stop_Bits;
            par_bit_reg <= par_bit_in;
        end
    end

    // Held in reset while idle so the start bit begins a full period.
    uart_bit_timer #(
        .CONFIG_DATA_WIDTH(CONFIG_DATA_WIDTH)
    ) u_bit_timer (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .load    (state_reg == IDLE),
        .divisor (div_reg),
        .bit_end (bit_end)
    );

    // FSM state, shift register, counters and registered line/done outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            serial_reg   <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            serial_reg   <= serial_next;
            done_reg     <= done_next;
        end
    end

    // Next-state logic; the line value is derived from the next state so it is registered.
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        done_next     = 1'b0;
        serial_next   = 1'b1;

        unique case (state_reg)
            IDLE: begin
                if (tx_if.i_Tx_DV) begin
                    state_next    = START;
                    shift_next    = tx_if.i_Tx_Byte;
                    bit_cnt_next  = '0;
                    stop_cnt_next = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == nbits_reg - 4'd1) begin
                        bit_cnt_next = '0;
                        state_next   = (parity_reg == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_reg && !stop_cnt_reg) begin
                        stop_cnt_next = 1'b1;
                    end else begin
                        stop_cnt_next = 1'b0;
                        state_next    = IDLE;
                        done_next     = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   serial_next = 1'b0;
            DATA:    serial_next = shift_next[0];
            PARITY:  serial_next = par_bit_reg;
            default: serial_next = 1'b1;
        endcase
    end

    assign tx_if.o_Tx_Ready  = (state_reg == IDLE);
    assign tx_if.o_Tx_Active = (state_reg != IDLE);
    assign tx_if.o_Tx_Serial = serial_reg;
    assign tx_if.o_Tx_Done   = done_reg;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: each accepted frame pushes its expected
// line sequence; a monitor reconstructs the frame cycle by cycle and compares.
module tb_uart_tx_cfg;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          div;
        int          acc;
        logic [7:0]  data;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   last_acc;
    exp_t sb[$];

    uart_tx_cfg_if #(.UART_DATA_WIDTH(8), .CONFIG_DATA_WIDTH(32)) bus ();

    uart_tx_cfg #(
        .UART_DATA_WIDTH(8),
        .CONFIG_DATA_WIDTH(32)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .tx_if   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference frame: start, clamped data LSB first, optional parity, stop bit(s).
    function automatic exp_t build(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par,
                                   input logic st, input int div, input int acc);
        exp_t e;
        int   n;
        int   k;
        logic p;
        n = (nb < 4'd5) ? 5 : ((nb > 4'd8) ? 8 : int'(nb));
        e.bits = '0;
        k = 0;
        p = 1'b0;
        e.bits[k] = 1'b0;
        k++;
        for (int i = 0; i < n; i++) begin
            e.bits[k] = d[i];
            p = p ^ d[i];
            k++;
        end
        if (par == 2'b01) begin
            e.bits[k] = p;
            k++;
        end else if (par == 2'b10) begin
            e.bits[k] = ~p;
            k++;
        end
        e.bits[k] = 1'b1;
        k++;
        if (st) begin
            e.bits[k] = 1'b1;
            k++;
        end
        e.nbits = k;
        e.div   = div;
        e.acc   = acc;
        e.data  = d;
        return e;
    endfunction

    // Monitor: samples every bit at its first cycle, checks it stays stable, and
    // checks Active/Ready/Done over the frame and in the cycle after it.
    initial begin : monitor
        logic [15:0] obs;
        int unstable, act_bad, done_bad, rdy_bad;
        int off, per, total;
        exp_t e;
        obs = '0;
        unstable = 0; act_bad = 0; done_bad = 0; rdy_bad = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e     = sb[0];
                per   = e.div + 1;
                total = e.nbits * per;
                off   = cyc - e.acc - 1;
                if (off == 0) begin
                    obs = '0;
                    unstable = 0; act_bad = 0; done_bad = 0; rdy_bad = 0;
                end
                if (off >= 0 && off < total) begin
                    if ((off % per) == 0) obs[off / per] = bus.o_Tx_Serial;
                    else if (bus.o_Tx_Serial !== obs[off / per]) unstable++;
                    if (bus.o_Tx_Active !== 1'b1) act_bad++;
                    if (bus.o_Tx_Done !== 1'b0) done_bad++;
                    if (bus.o_Tx_Ready !== 1'b0) rdy_bad++;
                end else if (off == total) begin
                    check_eq("frame_bits", 32'(obs), 32'(e.bits));
                    check_eq("bit_stable", unstable, 0);
                    check_eq("active_in_frame", act_bad, 0);
                    check_eq("done_early", done_bad, 0);
                    check_eq("ready_in_frame", rdy_bad, 0);
                    check_eq("done_pulse", 32'(bus.o_Tx_Done), 1);
                    check_eq("ready_at_end", 32'(bus.o_Tx_Ready), 1);
                    check_eq("active_at_end", 32'(bus.o_Tx_Active), 0);
                    $display("frame acc=%0d data=%h bits=%0d div=%0d line=%h expect=%h",
                             e.acc, e.data, e.nbits, e.div, obs, e.bits);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Present a frame and wait for it to be accepted; keep_dv leaves DV high afterwards.
    task automatic send(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par,
                        input logic st, input int div, input bit keep_dv);
        bit ok;
        @(posedge clk);
        #1;
        bus.i_Tx_Byte        = d;
        bus.i_Num_Bits       = nb;
        bus.i_Parity         = par;
        bus.i_Stop_Bits      = st;
        bus.uart_config_data = div;
        bus.i_Tx_DV          = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (bus.o_Tx_Ready) begin
                ok = 1'b1;
                last_acc = cyc;
                sb.push_back(build(d, nb, par, st, div, cyc));
                @(posedge clk);
                #1;
                if (!keep_dv) bus.i_Tx_DV = 1'b0;
            end
        end
        if (!ok) begin
            check_eq("accept_timeout", 0, 1);
            bus.i_Tx_DV = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            check_eq("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin : stimulus
        int a1, a2, n_done, n_act;
        n_cmp = 0;
        n_bad = 0;
        last_acc = 0;
        rst = 1'b1;
        bus.i_Tx_DV = 1'b0;
        bus.i_Tx_Byte = '0;
        bus.i_Num_Bits = 4'd8;
        bus.i_Parity = 2'b00;
        bus.i_Stop_Bits = 1'b0;
        bus.uart_config_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_serial", 32'(bus.o_Tx_Serial), 1);
        check_eq("rst_ready", 32'(bus.o_Tx_Ready), 1);
        check_eq("rst_active", 32'(bus.o_Tx_Active), 0);
        check_eq("rst_done", 32'(bus.o_Tx_Done), 0);
        rst = 1'b0;

        // 8N1 div 3, 7E1 div 1, 6O2 div 0
        send(8'hA5, 4'd8, 2'b00, 1'b0, 3, 1'b0);
        drain();
        send(8'hC1, 4'd7, 2'b01, 1'b0, 1, 1'b0);
        drain();
        send(8'h3F, 4'd6, 2'b10, 1'b1, 0, 1'b0);
        drain();

        // Back-to-back with DV held: second accept lands in the first frame's Done cycle
        send(8'h55, 4'd8, 2'b00, 1'b0, 2, 1'b1);
        a1 = last_acc;
        send(8'hAA, 4'd8, 2'b00, 1'b0, 2, 1'b0);
        a2 = last_acc;
        check_eq("b2b_gap", a2 - a1, 31);
        drain();

        // Length clamping and parity code 11
        send(8'hFF, 4'd2, 2'b11, 1'b0, 1, 1'b0);
        drain();
        send(8'h81, 4'd15, 2'b01, 1'b1, 0, 1'b0);
        drain();

        // Busy and config isolation
        send(8'h12, 4'd8, 2'b00, 1'b0, 3, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        bus.uart_config_data = 7;
        bus.i_Tx_Byte = 8'hFF;
        bus.i_Num_Bits = 4'd5;
        bus.i_Parity = 2'b01;
        bus.i_Tx_DV = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.i_Tx_DV = 1'b0;
        drain();
        send(8'h34, 4'd8, 2'b00, 1'b0, 7, 1'b0);
        drain();

        // Reset during data bit 3, together with DV
        send(8'h3C, 4'd8, 2'b00, 1'b0, 3, 1'b0);
        a1 = last_acc;
        for (int i = 0; i < 100 && cyc < a1 + 18; i++) @(negedge clk);
        sb.delete();
        rst = 1'b1;
        bus.i_Tx_DV = 1'b1;
        bus.i_Tx_Byte = 8'h77;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_serial", 32'(bus.o_Tx_Serial), 1);
        check_eq("midrst_ready", 32'(bus.o_Tx_Ready), 1);
        check_eq("midrst_active", 32'(bus.o_Tx_Active), 0);
        check_eq("midrst_done", 32'(bus.o_Tx_Done), 0);
        rst = 1'b0;
        bus.i_Tx_DV = 1'b0;
        n_done = 0;
        n_act = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_Tx_Done) n_done++;
            if (bus.o_Tx_Active) n_act++;
        end
        check_eq("midrst_no_done", n_done, 0);
        check_eq("midrst_idle", n_act, 0);
        send(8'h96, 4'd8, 2'b00, 1'b0, 3, 1'b0);
        drain();

        // A few mixed formats
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
